sync_event_arbiter: RTL and testbench

Multi-channel event scheduler for the destination clock domain. It synchronises NUM_CH asynchronous request lines, detects their rising edges and latches each edge as a pending event. It then grants pending events one at a time, round-robin, to a single downstream consumer over a valid/ready handshake. It sits between asynchronous sources (other clock domains, pads) and the single shared event-handling resource on CLK.

---
 rtl/sync_evt_pkg.sv | 43 ++++
 rtl/sync_stage_chain.sv | 32 +++
 rtl/sync_event_arbiter.sv | 121 ++++++++++++
 tb/tb_sync_event_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sync_evt_pkg.sv
// sync_evt_pkg
//   Shared definitions for sync_event_arbiter:
//   - MIN_SYNC_STAGES : smallest legal synchroniser depth
//   - MAX_CH / MAX_CH_W : widest channel vector the search function handles
//   - out_state_t     : output register state (IDLE / PRESENT)
//   - rr_search       : round-robin search over a pending vector.
//                       Returns the found flag and drives the index output.
package sync_evt_pkg;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_CH          = 16;
  localparam int MAX_CH_W        = 4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } out_state_t;

  // Scan pend ascending from ptr, wrapping at n-1 back to 0, and return the
  // first set bit. Offsets are walked from the far end down so that the last
  // hit written is the one closest to ptr.
  function automatic logic rr_search(input  logic [MAX_CH-1:0] pend,
                                     input  int                ptr,
                                     input  int                n,
                                     output int                idx);
    logic found;
    int   c;
    found = 1'b0;
    idx   = 0;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (k < n) begin
        c = ptr + k;
        if (c >= n) c = c - n;
        if (pend[c[MAX_CH_W-1:0]]) begin
          found = 1'b1;
          idx   = c;
        end
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/sync_stage_chain.sv
// sync_stage_chain
//   WIDTH independent NUM_STAGES-deep flop chains used as clock-domain
//   synchronisers. All stages reset to 0.
// Ports:
//   CLK   : destination clock
//   RST_n : asynchronous active-low reset
//   d     : asynchronous inputs
//   q     : synchronised outputs (last stage)
module sync_stage_chain #(
  parameter int WIDTH      = 4,
  parameter int NUM_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [NUM_STAGES];

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < NUM_STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < NUM_STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[NUM_STAGES-1];

endmodule

// File: rtl/sync_event_arbiter.sv
// sync_event_arbiter
//   Synchronises NUM_CH asynchronous event lines, latches each rising edge as
//   a pending event and hands pending events one at a time, round-robin, to a
//   single consumer over a valid/ready handshake.
// Ports:
//   CLK       : destination clock
//   RST_n     : asynchronous active-low reset
//   ASYNC_EVT : asynchronous level inputs, one event per rising edge
//   EVT_READY : consumer accepts EVT_ID when EVT_VALID && EVT_READY
//   OVF_CLR   : synchronous pulse clearing all OVERFLOW bits
//   EVT_VALID : a granted event is presented
//   EVT_ID    : index of the granted channel
//   PENDING   : latched events not yet granted
//   OVERFLOW  : sticky per-channel dropped-event flags
module sync_event_arbiter
  import sync_evt_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int NUM_STAGES = 2,
  localparam int ID_W       = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic [NUM_CH-1:0] ASYNC_EVT,
  input  logic              EVT_READY,
  input  logic              OVF_CLR,
  output logic              EVT_VALID,
  output logic [ID_W-1:0]   EVT_ID,
  output logic [NUM_CH-1:0] PENDING,
  output logic [NUM_CH-1:0] OVERFLOW
);

  if (NUM_STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("sync_event_arbiter: NUM_STAGES below minimum");
  end

  // Stage p0: synchroniser output
  logic [NUM_CH-1:0] sync_p0;

  sync_stage_chain #(
    .WIDTH      (NUM_CH),
    .NUM_STAGES (NUM_STAGES)
  ) u_sync (
    .CLK   (CLK),
    .RST_n (RST_n),
    .d     (ASYNC_EVT),
    .q     (sync_p0)
  );

  // Stage p1: edge detect against the delayed copy
  logic [NUM_CH-1:0] dly_p1;
  logic [NUM_CH-1:0] rise_p1;
  assign rise_p1 = sync_p0 & ~dly_p1;

  // Stage p2: pending/overflow registers, arbitration and output register
  logic [NUM_CH-1:0] pending_p2;
  logic [NUM_CH-1:0] overflow_p2;
  logic [ID_W-1:0]   ptr_p2;
  logic [ID_W-1:0]   id_p2;
  out_state_t        state_p2;

  logic [MAX_CH-1:0] pend_ext;
  logic              found;
  int                gidx;
  logic              load;
  logic [NUM_CH-1:0] gnt_mask;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   ptr_nxt;

  always_comb begin
    pend_ext               = '0;
    pend_ext[NUM_CH-1:0]   = pending_p2;
    gidx                   = 0;
    found                  = rr_search(pend_ext, int'(ptr_p2), NUM_CH, gidx);
    load                   = (state_p2 == ST_IDLE) || EVT_READY;
    gnt_id                 = ID_W'(gidx);
    ptr_nxt                = (gidx == NUM_CH - 1) ? '0 : ID_W'(gidx + 1);
    gnt_mask               = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (load && found && (gidx == i)) gnt_mask[i] = 1'b1;
    end
  end

  // A rise coinciding with its own channel's grant re-arms PENDING, so the new
  // event is kept rather than counted as dropped.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      dly_p1      <= '0;
      pending_p2  <= '0;
      overflow_p2 <= '0;
    end else begin
      dly_p1      <= sync_p0;
      pending_p2  <= (pending_p2 & ~gnt_mask) | rise_p1;
      overflow_p2 <= (OVF_CLR ? '0 : overflow_p2) |
                     (rise_p1 & pending_p2 & ~gnt_mask);
    end
  end

  // Output register FSM: holds while presented and not accepted.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_p2 <= ST_IDLE;
      id_p2    <= '0;
      ptr_p2   <= '0;
    end else if (load) begin
      if (found) begin
        state_p2 <= ST_PRESENT;
        id_p2    <= gnt_id;
        ptr_p2   <= ptr_nxt;
      end else begin
        state_p2 <= ST_IDLE;
      end
    end
  end

  assign EVT_VALID = (state_p2 == ST_PRESENT);
  assign EVT_ID    = id_p2;
  assign PENDING   = pending_p2;
  assign OVERFLOW  = overflow_p2;

endmodule

// File: tb/tb_sync_event_arbiter.sv
// tb_sync_event_arbiter
//   Directed bench for sync_event_arbiter in its default configuration
//   (NUM_CH=4, NUM_STAGES=2). Inputs change and outputs are sampled on the
//   falling clock edge.
module tb_sync_event_arbiter;

  logic       CLK;
  logic       RST_n;
  logic [3:0] ASYNC_EVT;
  logic       EVT_READY;
  logic       OVF_CLR;
  logic       EVT_VALID;
  logic [1:0] EVT_ID;
  logic [3:0] PENDING;
  logic [3:0] OVERFLOW;

  int n_chk  = 0;
  int n_pass = 0;

  sync_event_arbiter #(
    .NUM_CH     (4),
    .NUM_STAGES (2)
  ) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .ASYNC_EVT (ASYNC_EVT),
    .EVT_READY (EVT_READY),
    .OVF_CLR   (OVF_CLR),
    .EVT_VALID (EVT_VALID),
    .EVT_ID    (EVT_ID),
    .PENDING   (PENDING),
    .OVERFLOW  (OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  int vcnt;
  int id0cnt;

  initial begin
    RST_n     = 1'b0;
    ASYNC_EVT = 4'b0000;
    EVT_READY = 1'b1;
    OVF_CLR   = 1'b0;
    tick(2);
    chk("rst_valid",    32'(EVT_VALID), 32'd0);
    chk("rst_id",       32'(EVT_ID),    32'd0);
    chk("rst_pending",  32'(PENDING),   32'd0);
    chk("rst_overflow", 32'(OVERFLOW),  32'd0);
    RST_n = 1'b1;
    tick(2);

    // Fairness: all four channels at once, ptr=0.
    ASYNC_EVT = 4'b1111;
    tick(3);
    chk("fair_pending", 32'(PENDING), 32'hf);
    chk("fair_v_pre",   32'(EVT_VALID), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("fair_seq", {31'(EVT_VALID), 1'b0} | 32'(EVT_ID), {31'd1, 1'b0} | 32'(i));
    end
    tick(1);
    chk("fair_v_end",  32'(EVT_VALID), 32'd0);
    chk("fair_p_end",  32'(PENDING),   32'd0);
    ASYNC_EVT = 4'b0000;
    tick(4);

    // Backpressure: channels 1 and 3 with consumer stalled.
    EVT_READY = 1'b0;
    ASYNC_EVT = 4'b1010;
    tick(4);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {30'(EVT_VALID), EVT_ID}, {30'd1, 2'd1});
      tick(1);
    end
    chk("bp_pending", 32'(PENDING), 32'h8);
    EVT_READY = 1'b1;
    tick(1);
    chk("bp_next", {30'(EVT_VALID), EVT_ID}, {30'd1, 2'd3});
    tick(1);
    chk("bp_idle", 32'(EVT_VALID), 32'd0);
    ASYNC_EVT = 4'b0000;
    tick(4);

    // Overflow: output holds ch 0, ch 1 pulsed twice.
    EVT_READY = 1'b0;
    ASYNC_EVT = 4'b0001;
    tick(4);
    chk("ovf_hold0", {30'(EVT_VALID), EVT_ID}, {30'd1, 2'd0});
    for (int p = 0; p < 2; p++) begin
      ASYNC_EVT[1] = 1'b1;
      tick(4);
      ASYNC_EVT[1] = 1'b0;
      tick(4);
    end
    chk("ovf_flag",    32'(OVERFLOW), 32'h2);
    chk("ovf_pending", 32'(PENDING),  32'h2);
    chk("ovf_still0",  {30'(EVT_VALID), EVT_ID}, {30'd1, 2'd0});
    OVF_CLR = 1'b1;
    tick(1);
    OVF_CLR = 1'b0;
    chk("ovf_clr", 32'(OVERFLOW), 32'h0);
    EVT_READY = 1'b1;
    tick(1);
    chk("ovf_drain", {30'(EVT_VALID), EVT_ID}, {30'd1, 2'd1});
    tick(1);
    chk("ovf_idle", 32'(EVT_VALID), 32'd0);
    ASYNC_EVT = 4'b0000;
    tick(4);

    // Single event on ch 2: valid after the fourth edge, for one cycle.
    ASYNC_EVT = 4'b0100;
    tick(3);
    chk("single_pend", 32'(PENDING),   32'h4);
    chk("single_v0",   32'(EVT_VALID), 32'd0);
    tick(1);
    chk("single_id",   {30'(EVT_VALID), EVT_ID}, {30'd1, 2'd2});
    chk("single_pclr", 32'(PENDING), 32'h0);
    tick(1);
    chk("single_v1",   32'(EVT_VALID), 32'd0);
    ASYNC_EVT = 4'b0000;
    tick(4);

    // Coincidence: second rise of ch 2 lands on the edge that grants ch 2.
    EVT_READY = 1'b0;
    ASYNC_EVT = 4'b0001;
    tick(4);
    chk("coin_hold0", {30'(EVT_VALID), EVT_ID}, {30'd1, 2'd0});
    ASYNC_EVT = 4'b0101;
    tick(3);
    chk("coin_pend1", 32'(PENDING), 32'h4);
    ASYNC_EVT = 4'b0001;
    tick(4);
    ASYNC_EVT = 4'b0101;
    tick(2);
    EVT_READY = 1'b1;
    tick(1);
    chk("coin_grant", {30'(EVT_VALID), EVT_ID}, {30'd1, 2'd2});
    chk("coin_pend",  32'(PENDING),  32'h4);
    chk("coin_ovf",   32'(OVERFLOW), 32'h0);
    tick(1);
    chk("coin_second", {30'(EVT_VALID), EVT_ID}, {30'd1, 2'd2});
    tick(1);
    chk("coin_idle", 32'(EVT_VALID), 32'd0);
    ASYNC_EVT = 4'b0000;
    tick(4);

    // Reset mid-operation with PENDING=1010 and a presented event.
    EVT_READY = 1'b0;
    ASYNC_EVT = 4'b0001;
    tick(4);
    ASYNC_EVT = 4'b1011;
    tick(3);
    chk("mid_pend",  32'(PENDING),   32'ha);
    chk("mid_valid", 32'(EVT_VALID), 32'd1);
    #2;
    RST_n = 1'b0;
    #1;
    chk("arst_valid",   32'(EVT_VALID), 32'd0);
    chk("arst_id",      32'(EVT_ID),    32'd0);
    chk("arst_pending", 32'(PENDING),   32'd0);
    chk("arst_ovf",     32'(OVERFLOW),  32'd0);
    ASYNC_EVT = 4'b0001;
    EVT_READY = 1'b1;
    tick(2);
    RST_n = 1'b1;
    vcnt   = 0;
    id0cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (EVT_VALID) begin
        vcnt++;
        if (EVT_ID == 2'd0) id0cnt++;
      end
    end
    chk("post_rst_valid_cnt", 32'(vcnt),   32'd1);
    chk("post_rst_id0_cnt",   32'(id0cnt), 32'd1);
    chk("post_rst_pending",   32'(PENDING), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
